// File: rtl/pin_in_cond.sv
// pin_in_cond: synchronizes and optionally glitch-filters raw pad inputs, with edge pulses and sticky events
//   clk      core clock, rising edge
//   res      asynchronous active-high reset
//   pin_raw  unsynchronized pad inputs
//   pin_in   conditioned pin values
//   rise     one-cycle pulse on a 0->1 change of pin_in
//   fall     one-cycle pulse on a 1->0 change of pin_in
//   evt      sticky change flags, cleared by writing 1 to evt_clr
//   evt_clr  write-one-to-clear for evt
//   rdy      high once the synchronizer warm-up has finished
// Optional glitch filter: define PIN_IN_FILTER_EN (FILT_LEN is used only then).
module pin_in_cond #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] pin_raw,
  output logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  input  logic [WIDTH-1:0] evt_clr,
  output logic             rdy
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pin_in_cond: SYNC_STAGES must be 2..4");
  end
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
    $error("pin_in_cond: FILT_LEN must be 1..15");
  end
  logic [SYNC_STAGES-1:0][WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] s_last, flt, chg;
  logic [WIDTH-1:0] pin_in_q, pin_in_d, rise_q, rise_d, fall_q, fall_d, evt_q, evt_d;
  logic [2:0] wu_q, wu_d;
  logic rdy_q, rdy_d, load;
  assign s_d    = {s_q[SYNC_STAGES-2:0], pin_raw};
  assign s_last = s_q[SYNC_STAGES-1];
  assign load   = !rdy_q && wu_q == 3'(SYNC_STAGES - 1);
`ifdef PIN_IN_FILTER_EN
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = '0;
    flt   = pin_in_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (rdy_q && s_last[i] != pin_in_q[i]) begin
        if (cnt_q[i] == 4'(FILT_LEN - 1)) flt[i] = s_last[i];
        else cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge res)
    if (res) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign flt = s_last;
`endif
  // The loading edge takes the value s_last is about to hold, so pin_in is
  // valid the moment rdy rises and the following steady edge sees no change.
  always_comb begin
    chg      = rdy_q ? flt ^ pin_in_q : '0;
    pin_in_d = rdy_q ? flt : load ? s_q[SYNC_STAGES-2] : pin_in_q;
    rise_d   = chg & flt;
    fall_d   = chg & ~flt;
    evt_d    = (evt_q & ~evt_clr) | chg;
    rdy_d    = rdy_q | load;
    wu_d     = rdy_q ? wu_q : wu_q + 3'd1;
  end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      s_q      <= '0;
      pin_in_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      evt_q    <= '0;
      wu_q     <= '0;
      rdy_q    <= 1'b0;
    end else begin
      s_q      <= s_d;
      pin_in_q <= pin_in_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      evt_q    <= evt_d;
      wu_q     <= wu_d;
      rdy_q    <= rdy_d;
    end
  assign pin_in = pin_in_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign evt    = evt_q;
  assign rdy    = rdy_q;
endmodule

// File: doc/pin_in_cond.md
Name: pin_in_cond

Overview:
- Input-direction counterpart of the pin output path. Conditions the 32 raw I/O pad inputs before the core samples them.
- Each pin gets a multi-stage synchronizer into the core clock domain and an optional per-pin glitch filter.
- Generates per-pin rise/fall pulses and sticky change-event flags with write-one-to-clear acknowledge.
- Sits between the bidirectional pad buffers and the core pin_in bus.

Parameters:
- WIDTH, 32: number of pins conditioned.
- SYNC_STAGES, 2: synchronizer flops per pin; legal range 2..4.
- FILT_LEN, 4: consecutive differing samples required before the filtered value changes; legal range 1..15; used only with the optional feature.

Ports:
- clk  input  1  core clock; all flops on rising edge.
- res  input  1  asynchronous, active-high reset.
- pin_raw  input  WIDTH  unsynchronized pad input values.
- pin_in  output  WIDTH  conditioned pin values to the core.
- rise  output  WIDTH  one-cycle pulse per pin on a 0->1 change of pin_in.
- fall  output  WIDTH  one-cycle pulse per pin on a 1->0 change of pin_in.
- evt  output  WIDTH  sticky per-pin change flag.
- evt_clr  input  WIDTH  write-one-to-clear for evt; sampled each cycle.
- rdy  output  1  high once warm-up completes; stays high until reset.

Behaviour:
- Reset (async, res=1): synchronizer flops, pin_in, rise, fall, evt, filter counters, warm-up counter and rdy all clear to 0.
- Synchronizer: s[0] captures pin_raw each edge; s[k] <= s[k-1]; s_last = s[SYNC_STAGES-1]. No combinational path from pin_raw to any output.
- Warm-up:
  - After res deasserts, a counter runs for SYNC_STAGES edges.
  - At edge SYNC_STAGES, pin_in <= s_last directly and rdy <= 1.
  - rise, fall and evt stay 0 during warm-up and on that loading edge; filter counters stay 0.
- Steady state (rdy=1), per pin, without filter:
  - pin_in <= s_last.
  - A pin_raw change set up before edge E appears on pin_in after edge E+SYNC_STAGES.
- Edge pulses:
  - rise/fall are registered and assert on the same edge pin_in changes.
  - Each is high for exactly one cycle per change.
  - Back-to-back toggles give alternating rise and fall on consecutive cycles.
- Events:
  - evt[i] <= (evt[i] & ~evt_clr[i]) | rise[i]-set | fall[i]-set, where set means pin_in[i] changes on this edge.
  - A set and a clear on the same edge: set wins, evt stays 1.
  - evt_clr on a pin whose evt=0 has no effect.
  - evt_clr during warm-up is ignored (evt is already 0).
- Reset mid-operation: everything clears immediately; warm-up repeats after deassertion; no edge pulses result from the reload.
- All pins are independent; per-pin logic is identical; no cross-pin interaction.

Optional Feature:
- Macro: PIN_IN_FILTER_EN.
- Defined:
  - Each pin has a 4-bit counter cnt[i].
  - When rdy=1 and s_last[i] != pin_in[i], cnt increments. When s_last[i] == pin_in[i], cnt resets to 0.
  - When cnt[i] == FILT_LEN-1 and s_last[i] still differs, pin_in[i] toggles and cnt <= 0 on that edge.
  - A stable change therefore reaches pin_in after edge E+SYNC_STAGES+FILT_LEN-1.
  - Pulses shorter than FILT_LEN cycles at s_last are fully rejected: no pin_in change, no rise/fall, no evt.
  - FILT_LEN=1 behaves identically to the unfiltered path.
- Not defined:
  - No counters are instantiated; pin_in <= s_last in steady state; FILT_LEN is ignored.

Test Plan:
- Warm-up: pin_raw=32'h8000_0001 held through reset release, SYNC_STAGES=2 -> rdy=0 at edge 1; at edge 2 rdy=1 and pin_in=32'h8000_0001; rise=fall=evt=0 throughout.
- Latency and pulse, no filter: after rdy, pin_raw[5] 0->1 set up before edge E -> pin_in[5]=1 after edge E+2; rise[5]=1 for exactly one cycle; evt[5]=1 until cleared.
- Event clear race: evt[5]=1 and evt_clr[5]=1 on the same edge as a fall on pin 5 -> evt[5] stays 1. A later evt_clr[5]=1 alone -> evt[5]=0 the next cycle.
- Filter, with PIN_IN_FILTER_EN and FILT_LEN=4:
  - A 3-cycle pulse on pin_raw[7] -> pin_in[7], rise[7] and evt[7] never change.
  - A held change -> pin_in[7] updates after edge E+5 with one rise pulse.
- Toggle stress, no filter: pin_raw[0] toggles every cycle -> pin_in[0] follows delayed by 2 edges; rise/fall alternate each cycle; other pins stay 0.
- Reset mid-operation: assert res while pin_raw=32'hFFFF_FFFF and evt nonzero -> all outputs 0 immediately. After release, pin_in=32'hFFFF_FFFF at edge 2 with no rise pulses.
